// File: rtl/parity_frame_unit_pkg.sv
// Shared encodings for the frame parity unit: parity modes, check/generate
// select, FSM states, and the mode-to-parity-bit mapping.
package parity_frame_unit_pkg;

   typedef enum logic [1:0] {
      PAR_EVEN  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_MARK  = 2'b10,
      PAR_SPACE = 2'b11
   } par_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_DONE  = 2'b10
   } pfu_state_e;

   localparam logic CHK_GEN   = 1'b0;
   localparam logic CHK_CHECK = 1'b1;

   // Final parity bit for a frame given its mode and the XOR of all data bits.
   function automatic logic par_apply(input par_mode_e mode, input logic acc);
      logic p;
      case (mode)
         PAR_EVEN:  p = acc;
         PAR_ODD:   p = ~acc;
         PAR_MARK:  p = 1'b1;
         default:   p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/parity_frame_unit_par_reduce.sv
// XOR-reduce of one data word. Kept separate so a pipelined tree can be
// dropped in for wide words without touching the frame FSM.
module par_reduce #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  par
);

   assign par = ^data;

endmodule

// File: rtl/parity_frame_unit.sv
// Frame parity unit: accumulates XOR parity over 1..MAX_WORDS words accepted
// on a valid/ready handshake, then presents one registered result for a
// single cycle. In check mode the result is compared with the parity bit
// received alongside the last word.
module parity_frame_unit
   import parity_frame_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WORDS  = 16,
   parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_MODE,
   input  logic                  CHK_MODE,
   input  logic [CNT_W-1:0]      FRAME_LEN,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic                  IN_PAR,
   output logic                  PAR_BIT,
   output logic                  PAR_VALID,
   output logic                  PAR_ERR,
   output logic                  BUSY
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   pfu_state_e       state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   par_mode_e        mode_q, mode_d;
   logic             chk_q, chk_d;
   logic             par_bit_q, par_bit_d;
   logic             par_err_q, par_err_d;
   logic             par_valid_q, par_valid_d;

   logic             word_par;
   logic [CNT_W-1:0] eff_len;

   par_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_reduce (
      .data (IN_DATA),
      .par  (word_par)
   );

   // Ready depends only on state: the result cycle is the single stall slot.
   assign IN_READY  = (state_q != ST_DONE);
   assign BUSY      = (state_q != ST_IDLE);
   assign PAR_BIT   = par_bit_q;
   assign PAR_ERR   = par_err_q;
   assign PAR_VALID = par_valid_q;

   // Map the requested length onto 1..MAX_WORDS.
   always_comb begin
      if (FRAME_LEN == '0)
         eff_len = ONE;
      else if (FRAME_LEN > MAX_LEN)
         eff_len = MAX_LEN;
      else
         eff_len = FRAME_LEN;
   end

   // Next-state logic: frame start latches config, each accept folds one
   // word in, and the final accept computes the result and received-bit
   // comparison so both are registered for the DONE cycle.
   always_comb begin
      logic             start, step, accept;
      logic             nxt_acc;
      logic [CNT_W-1:0] nxt_cnt, cur_len;
      par_mode_e        cur_mode;
      logic             cur_chk;

      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      mode_d      = mode_q;
      chk_d       = chk_q;
      par_bit_d   = par_bit_q;
      par_err_d   = par_err_q;
      par_valid_d = 1'b0;

      accept   = IN_VALID & IN_READY;
      start    = accept & PAR_EN & (state_q == ST_IDLE);
      step     = accept & (state_q == ST_ACCUM);
      cur_len  = start ? eff_len : len_q;
      cur_mode = start ? par_mode_e'(PAR_MODE) : mode_q;
      cur_chk  = start ? CHK_MODE : chk_q;
      nxt_cnt  = start ? ONE : cnt_q + ONE;
      nxt_acc  = start ? word_par : (acc_q ^ word_par);

      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (start || step) begin
               acc_d  = nxt_acc;
               cnt_d  = nxt_cnt;
               len_d  = cur_len;
               mode_d = cur_mode;
               chk_d  = cur_chk;
               if (nxt_cnt == cur_len) begin
                  state_d     = ST_DONE;
                  par_bit_d   = par_apply(cur_mode, nxt_acc);
                  par_err_d   = (cur_chk == CHK_CHECK) && (par_bit_d != IN_PAR);
                  par_valid_d = 1'b1;
               end else begin
                  state_d = ST_ACCUM;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; async reset aborts any frame in flight.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         acc_q       <= 1'b0;
         cnt_q       <= '0;
         len_q       <= ONE;
         mode_q      <= PAR_EVEN;
         chk_q       <= CHK_GEN;
         par_bit_q   <= 1'b0;
         par_err_q   <= 1'b0;
         par_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         chk_q       <= chk_d;
         par_bit_q   <= par_bit_d;
         par_err_q   <= par_err_d;
         par_valid_q <= par_valid_d;
      end
   end

endmodule

// File: tb/tb_parity_frame_unit.sv
// Directed bench for parity_frame_unit with hand-computed expectations.
module tb_parity_frame_unit;

   localparam int DW    = 8;
   localparam int MAXW  = 16;
   localparam int CNT_W = $clog2(MAXW + 1);

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             PAR_EN = 1'b0;
   logic [1:0]       PAR_MODE = 2'b00;
   logic             CHK_MODE = 1'b0;
   logic [CNT_W-1:0] FRAME_LEN = '0;
   logic [DW-1:0]    IN_DATA = '0;
   logic             IN_VALID = 1'b0;
   logic             IN_READY;
   logic             IN_PAR = 1'b0;
   logic             PAR_BIT, PAR_VALID, PAR_ERR, BUSY;

   int checks = 0;
   int fails  = 0;
   int pv_cnt = 0;
   int pv0;

   parity_frame_unit #(.DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
      .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE),
      .CHK_MODE(CHK_MODE), .FRAME_LEN(FRAME_LEN), .IN_DATA(IN_DATA),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PAR(IN_PAR),
      .PAR_BIT(PAR_BIT), .PAR_VALID(PAR_VALID), .PAR_ERR(PAR_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Count result pulses mid-cycle.
   always @(negedge CLK) if (PAR_VALID) pv_cnt <= pv_cnt + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK); #1;
   endtask

   // Present one word, wait (bounded) for ready, return #1 after the accept edge.
   task automatic send(input logic [DW-1:0] d, input logic p);
      IN_DATA = d; IN_PAR = p; IN_VALID = 1'b1;
      for (int i = 0; i < 8 && !IN_READY; i++) cyc();
      if (!IN_READY) check_val("ready_timeout", 0, 1);
      cyc();
      IN_VALID = 1'b0;
   endtask

   task automatic cfg(input logic en, input logic [1:0] m, input logic c, input logic [CNT_W-1:0] l);
      PAR_EN = en; PAR_MODE = m; CHK_MODE = c; FRAME_LEN = l;
   endtask

   initial begin
      // reset state
      #12;
      check_val("rst_bit", PAR_BIT, 0);
      check_val("rst_valid", PAR_VALID, 0);
      check_val("rst_err", PAR_ERR, 0);
      check_val("rst_busy", BUSY, 0);
      check_val("rst_ready", IN_READY, 1);
      @(negedge CLK); RST = 1'b1;
      cyc();

      // 1: single word, even then odd; A5 has four ones
      cfg(1, 2'b00, 0, 1);
      send(8'hA5, 0);
      check_val("t1_even_valid", PAR_VALID, 1);
      check_val("t1_even_bit", PAR_BIT, 0);
      check_val("t1_even_err", PAR_ERR, 0);
      check_val("t1_done_ready", IN_READY, 0);
      cyc();
      check_val("t1_valid_pulse", PAR_VALID, 0);
      check_val("t1_ready_back", IN_READY, 1);
      cfg(1, 2'b01, 0, 1);
      send(8'hA5, 0);
      check_val("t1_odd_valid", PAR_VALID, 1);
      check_val("t1_odd_bit", PAR_BIT, 1);

      // 2: three words with gaps, 1^0^1 = 0 in even mode
      cyc();
      pv0 = pv_cnt;
      cfg(1, 2'b00, 0, 3);
      send(8'h01, 0);
      check_val("t2_busy", BUSY, 1);
      check_val("t2_no_early", PAR_VALID, 0);
      cyc(); check_val("t2_gap_ready", IN_READY, 1);
      cyc();
      send(8'h03, 0);
      check_val("t2_no_early2", PAR_VALID, 0);
      cyc(); cyc();
      send(8'h07, 0);
      check_val("t2_valid", PAR_VALID, 1);
      check_val("t2_bit", PAR_BIT, 0);
      check_val("t2_ready_low", IN_READY, 0);
      cyc();
      check_val("t2_one_pulse", pv_cnt - pv0, 1);
      check_val("t2_idle", BUSY, 0);

      // 3: check mode odd, FF^01 -> acc 1, odd -> 0
      cfg(1, 2'b01, 1, 2);
      send(8'hFF, 0);
      send(8'h01, 0);
      check_val("t3_bit", PAR_BIT, 0);
      check_val("t3_err_ok", PAR_ERR, 0);
      send(8'hFF, 0);
      send(8'h01, 1);
      check_val("t3_valid", PAR_VALID, 1);
      check_val("t3_err_bad", PAR_ERR, 1);
      cyc();
      check_val("t3_err_held", PAR_ERR, 1);

      // 4: mark / space with length 0, then clamp at MAX_WORDS
      cfg(1, 2'b10, 0, 0);
      send(8'h00, 0);
      check_val("t4_mark_valid", PAR_VALID, 1);
      check_val("t4_mark_bit", PAR_BIT, 1);
      check_val("t4_gen_err", PAR_ERR, 0);
      cfg(1, 2'b11, 0, 0);
      send(8'hFF, 0);
      check_val("t4_space_valid", PAR_VALID, 1);
      check_val("t4_space_bit", PAR_BIT, 0);
      cfg(1, 2'b00, 0, CNT_W'(MAXW + 5));
      send(8'h03, 0);
      for (int i = 1; i < MAXW - 1; i++) send(8'h01, 0);
      check_val("t4_clamp_early", PAR_VALID, 0);
      check_val("t4_clamp_busy", BUSY, 1);
      send(8'h01, 0);
      check_val("t4_clamp_valid", PAR_VALID, 1);
      check_val("t4_clamp_bit", PAR_BIT, 1);

      // 5: disabled words are dropped; prior result held
      cyc();
      pv0 = pv_cnt;
      cfg(0, 2'b00, 0, 1);
      for (int i = 0; i < 4; i++) begin
         send(8'h01, 0);
         check_val("t5_ready", IN_READY, 1);
         check_val("t5_busy", BUSY, 0);
      end
      cyc();
      check_val("t5_no_pulse", pv_cnt - pv0, 0);
      check_val("t5_bit_hold", PAR_BIT, 1);
      // config changes after start are ignored: even, length 3
      cfg(1, 2'b00, 0, 3);
      send(8'h01, 0);
      cfg(0, 2'b01, 0, 2);
      send(8'h00, 0);
      check_val("t5_len_latched", PAR_VALID, 0);
      send(8'h02, 0);
      check_val("t5_mid_valid", PAR_VALID, 1);
      check_val("t5_mode_latched", PAR_BIT, 0);

      // 6: reset mid-frame; first set PAR_BIT to 1 so the reset is visible
      cfg(1, 2'b10, 0, 1);
      send(8'h00, 0);
      check_val("t6_pre_bit", PAR_BIT, 1);
      cfg(1, 2'b00, 0, 4);
      send(8'h01, 0);
      send(8'h01, 0);
      pv0 = pv_cnt;
      RST = 1'b0;
      #2;
      check_val("t6_rst_busy", BUSY, 0);
      check_val("t6_rst_bit", PAR_BIT, 0);
      check_val("t6_rst_valid", PAR_VALID, 0);
      check_val("t6_rst_ready", IN_READY, 1);
      @(negedge CLK); RST = 1'b1;
      cyc();
      check_val("t6_no_pulse", pv_cnt - pv0, 0);
      send(8'h01, 0);
      send(8'h00, 0);
      send(8'h00, 0);
      check_val("t6_fresh_early", PAR_VALID, 0);
      send(8'h00, 0);
      check_val("t6_fresh_valid", PAR_VALID, 1);
      check_val("t6_fresh_bit", PAR_BIT, 1);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/parity_frame_unit.md
Name: parity_frame_unit

Overview:
- Parametrised successor to the single-word parity calculator.
- Accumulates parity over a multi-word frame (1..MAX_WORDS words of DATA_WIDTH bits) using a valid/ready handshake.
- Supports four parity modes and a generate/check mode: in check mode it compares against a received parity bit and flags mismatch.
- Sits between the TX/RX data path and the serializer/deserializer FSM.

Parameters:
DATA_WIDTH, 8, width of each data word
MAX_WORDS, 16, maximum words per frame
CNT_W, $clog2(MAX_WORDS+1), width of FRAME_LEN and internal word counter

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
PAR_EN  input  1  enable; 0 = words consumed, no parity result produced
PAR_MODE  input  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
CHK_MODE  input  1  0 generate, 1 check
FRAME_LEN  input  CNT_W  words per frame; 0 treated as 1, values >MAX_WORDS clamp to MAX_WORDS
IN_DATA  input  DATA_WIDTH  data word
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  unit accepts word when IN_VALID & IN_READY
IN_PAR  input  1  received parity bit; sampled with the last word of a frame (check mode)
PAR_BIT  output  1  computed parity, held until next result
PAR_VALID  output  1  one-cycle pulse, PAR_BIT/PAR_ERR valid
PAR_ERR  output  1  check-mode mismatch, valid with PAR_VALID, held until next result
BUSY  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset values: PAR_BIT=0, PAR_VALID=0, PAR_ERR=0, BUSY=0, IN_READY=1; FSM=IDLE, accumulator=0, counter=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - IN_READY=1.
  - On accept with PAR_EN=1: latch PAR_MODE, CHK_MODE and the effective length L, set acc=^IN_DATA and cnt=1.
  - If L==1: go DONE and latch IN_PAR. Otherwise go ACCUM.
  - On accept with PAR_EN=0: word dropped, stay IDLE, outputs unchanged.
- ACCUM:
  - IN_READY=1.
  - Each accept: acc ^= ^IN_DATA, cnt++.
  - The accept that makes cnt==L latches IN_PAR and goes to DONE.
  - IN_VALID low: hold state, no timeout.
- DONE (exactly one cycle):
  - IN_READY=0, PAR_VALID=1.
  - PAR_BIT = acc (even), ~acc (odd), 1 (mark), 0 (space).
  - PAR_ERR = CHK_MODE_latched & (PAR_BIT != IN_PAR_latched). PAR_ERR=0 in generate mode.
  - Next state IDLE unconditionally.
- Latency: PAR_VALID asserts the cycle after the last word is accepted. Throughput is L words per L+1 cycles.
- Config changes (PAR_MODE, CHK_MODE, FRAME_LEN) mid-frame are ignored; they take effect at the next frame start.
- PAR_EN deasserted mid-frame: frame completes normally (enable is sampled only at frame start).
- Async reset mid-frame: frame aborted, no PAR_VALID, all outputs return to reset values.
- PAR_BIT/PAR_ERR registered, no combinational path from inputs.
- IN_READY is a function of the FSM state only.

Decomposition:
- Shared package (e.g. parity_pkg):
  - PAR_MODE encodings: PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11.
  - FSM state encodings.
  - CHK_MODE constants.
- Sub-module par_reduce: combinational XOR-reduce of DATA_WIDTH bits. Natural place to pipeline later for wide DATA_WIDTH.
- FSM, counter and accumulator stay in parity_frame_unit.

Test Plan:
1. Reset release, generate even, FRAME_LEN=1, IN_DATA=8'hA5 -> next cycle PAR_VALID=1, PAR_BIT=0, PAR_ERR=0. Repeat with odd -> PAR_BIT=1.
2. FRAME_LEN=3, even, words 8'h01, 8'h03, 8'h07 with IN_VALID gaps of 2 cycles -> single PAR_VALID one cycle after 3rd accept, PAR_BIT=0 (1^0^1). IN_READY=0 only in that cycle.
3. Check mode, odd, FRAME_LEN=2, words 8'hFF, 8'h01, IN_PAR=0 on last word -> PAR_BIT=0, PAR_ERR=0. Rerun with IN_PAR=1 -> PAR_ERR=1.
4. Mark then space mode, FRAME_LEN=0, any data -> treated as 1 word, PAR_BIT=1 then 0. FRAME_LEN=MAX_WORDS+5 -> PAR_VALID after exactly MAX_WORDS accepts.
5. PAR_EN=0, stream 4 words -> IN_READY=1 throughout, no PAR_VALID, PAR_BIT holds prior value. Switch PAR_MODE/FRAME_LEN mid-frame -> result uses values latched at frame start.
6. Assert RST after 2 of 4 words -> outputs reset immediately, no PAR_VALID. After release, a fresh 4-word frame yields correct parity (no carry-over of the accumulator).
